// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// Word width, FSM encodings and state enum.
`ifndef WORD
`define WORD 64
`endif

package div_pkg;

  localparam int DIV_WIDTH = `WORD;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    RUN   = ST_RUN,
    FIX   = ST_FIX,
    DONE  = ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration.
// Shifts next dividend bit in, trial-subtracts the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  // Borrow out of the trial subtract means "restore"
  assign q_bit   = ~diff[WIDTH];
  assign new_rem = q_bit ? diff[WIDTH-1:0]
                         : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider sequencer.
// Stalls the pipeline while the restoring loop runs.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] rem_q;
  logic             sgn_q;
  logic             q_neg;
  logic             r_neg;
  logic [CW-1:0]    cnt;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .divisor (b_q),
    .bit_in  (acc_q[WIDTH-1]),
    .new_rem (step_rem),
    .q_bit   (step_q)
  );

  assign stall = ~reset & (
    (state == ST_SETUP) |
    (state == ST_RUN)   |
    (state == ST_FIX)   |
    ((state == ST_IDLE) & start));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      sgn_q       <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= dividend;
            b_q   <= divisor;
            sgn_q <= is_signed;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          acc_q <= a_mag;
          b_q   <= b_mag;
          rem_q <= '0;
          cnt   <= CW'(WIDTH);
          // Zero divisor skips the loop; raw dividend is the remainder
          if (b_q == '0) begin
            quotient    <= '0;
            remainder   <= a_q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= {acc_q[WIDTH-2:0], step_q};
          rem_q <= step_rem;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          quotient    <= q_neg ? -acc_q : acc_q;
          remainder   <= r_neg ? -rem_q : rem_q;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed + random bench for div_sequencer.
// Expected results are queued at issue and checked at done.
module tb_div_sequencer;

  localparam int W = 64;
  localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         stall;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .stall       (stall),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic sg,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] eq,
                       input logic [W-1:0] er,
                       input logic ez,
                       input int lat,
                       input string tag,
                       input bit inject);
    exp_t e;
    int   n;
    int   st_cnt;
    int   extra;
    e.q = eq; e.r = er; e.z = ez; e.lat = lat;
    exp_q.push_back(e);
    is_signed = sg; dividend = a; divisor = b; start = 1'b1;
    #1;
    check({tag, ".stall_req"}, W'(stall), W'(1));
    @(posedge clk); #1;
    start = 1'b0;
    dividend = '1; divisor = '1;
    n = 1; st_cnt = 0;
    while (!done && n < 200) begin
      if (stall) st_cnt++;
      if (inject && n == 10) begin
        start = 1'b1; is_signed = 1'b0;
        dividend = 64'd9; divisor = 64'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, W'(done), W'(1));
    if (exp_q.size() == 0) begin
      check({tag, ".sb_nonempty"}, W'(0), W'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, ".latency"}, W'(n), W'(e.lat));
      check({tag, ".quot"}, quotient, e.q);
      check({tag, ".rem"}, remainder, e.r);
      check({tag, ".dbz"}, W'(div_by_zero), W'(e.z));
      check({tag, ".stall_cycles"}, W'(st_cnt), W'(e.lat - 1));
      check({tag, ".stall_done"}, W'(stall), W'(0));
    end
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, W'(done), W'(0));
    check({tag, ".hold_q"}, quotient, eq);
    check({tag, ".hold_r"}, remainder, er);
    if (inject) begin
      extra = 0;
      repeat (80) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, ".no_extra_done"}, W'(extra), W'(0));
    end
  endtask

  logic signed [W-1:0] sa;
  logic signed [W-1:0] sd;
  logic        [W-1:0] ua;
  logic        [W-1:0] ud;
  int                  dcnt;

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    #1;
    check("rst.stall", W'(stall), W'(0));
    check("rst.done", W'(done), W'(0));
    check("rst.quot", quotient, '0);
    check("rst.rem", remainder, '0);
    check("rst.dbz", W'(div_by_zero), W'(0));
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 64'd57, 64'd8, 64'd7, 64'd1, 1'b0, 67, "udiv57_8", 1'b0);
    do_op(1'b1, -64'd57, 64'd8, -64'd7, -64'd1, 1'b0, 67, "sdiv-57_8", 1'b0);
    do_op(1'b1, 64'd57, -64'd8, -64'd7, 64'd1, 1'b0, 67, "sdiv57_-8", 1'b0);
    do_op(1'b0, 64'd100, 64'd0, 64'd0, 64'd100, 1'b1, 2, "udiv100_0", 1'b0);
    do_op(1'b1, -64'd5, 64'd0, 64'd0, -64'd5, 1'b1, 2, "sdiv-5_0", 1'b0);
    do_op(1'b1, MIN, -64'd1, MIN, 64'd0, 1'b0, 67, "sdivmin_-1", 1'b0);
    do_op(1'b0, 64'd57, 64'd8, 64'd7, 64'd1, 1'b0, 67, "inject", 1'b1);

    is_signed = 1'b0; dividend = 64'd57; divisor = 64'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    #1;
    check("midrun.stall_in_reset", W'(stall), W'(0));
    @(posedge clk); #1;
    check("midrun.stall", W'(stall), W'(0));
    check("midrun.done", W'(done), W'(0));
    check("midrun.quot", quotient, '0);
    check("midrun.rem", remainder, '0);
    check("midrun.dbz", W'(div_by_zero), W'(0));
    reset = 1'b0; start = 1'b0;
    #1;
    check("midrun.idle_stall", W'(stall), W'(0));
    dcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("midrun.no_done", W'(dcnt), W'(0));
    do_op(1'b0, 64'd57, 64'd8, 64'd7, 64'd1, 1'b0, 67, "after_rst", 1'b0);

    repeat (2) begin
      ua = {$urandom, $urandom};
      ud = {32'h0, $urandom} | 64'd1;
      do_op(1'b0, ua, ud, ua / ud, ua % ud, 1'b0, 67, "urand", 1'b0);
    end
    repeat (2) begin
      sa = {$urandom, $urandom};
      sd = {{32{1'b1}}, $urandom};
      if (sd == 0 || sd == -1) sd = -64'sd7;
      do_op(1'b1, sa, sd, sa / sd, sa % sd, 1'b0, 67, "srand", 1'b0);
    end

    check("sb_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, default `WORD (64), operand/result width.
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: is_signed  input  1  1 = SDIV (two's complement), 0 = UDIV; sampled with start.
REQ-006 SHALL have port: dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port: divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port: stall  output  1  hold PC/pipeline while division is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; results valid this cycle.
REQ-010 SHALL have port: quotient  output  WIDTH  registered quotient.
REQ-011 SHALL have port: remainder  output  WIDTH  registered remainder.
REQ-012 SHALL have port: div_by_zero  output  1  registered flag, valid with done.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, RUN, FIX, DONE.
REQ-014 SHALL transition IDLE->SETUP on start=1; otherwise stay in IDLE.
REQ-015 SHALL, in SETUP, latch operand magnitudes (abs value when is_signed), result signs (q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend)), and load iteration counter = WIDTH.
REQ-016 SHALL go SETUP->DONE when divisor==0, else SETUP->RUN.
REQ-017 SHALL, in RUN, perform one restoring shift-subtract step per cycle (WIDTH+1-bit partial remainder), decrement the counter, and go to FIX after exactly WIDTH RUN cycles.
REQ-018 SHALL, in FIX, negate quotient if q_neg and remainder if r_neg (signed only), then go to DONE.
REQ-019 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-020 SHALL produce latency: start-accepted cycle to done cycle = WIDTH+3 cycles normally; 2 cycles for divide-by-zero.
REQ-021 SHALL drive stall combinationally = (state in {SETUP, RUN, FIX}) OR (state==IDLE AND start), and stall=0 in DONE.
REQ-022 SHALL ignore start while not in IDLE (no queueing, no restart).
REQ-023 SHALL, on divisor==0, output quotient=0, remainder=dividend, div_by_zero=1.
REQ-024 SHALL, on signed MIN/-1, output quotient=MIN (wraps, 0x8000_0000_0000_0000 at WIDTH 64), remainder=0, div_by_zero=0.
REQ-025 SHALL hold quotient, remainder, div_by_zero stable from DONE until the next DONE.
REQ-026 SHALL round quotient toward zero; remainder takes dividend's sign.

Reset
REQ-027 SHALL, on reset=1 at a rising clk, enter IDLE from any state including mid-RUN, discarding the operation.
REQ-028 SHALL reset quotient=0, remainder=0, div_by_zero=0, done=0, counter=0.
REQ-029 SHALL drive stall=0 while reset=1, regardless of start.

Structure
REQ-030 SHALL place the state enum and DIV_WIDTH constant (= `WORD) in shared package div_pkg.
REQ-031 SHALL factor one restoring-division iteration into combinational sub-module div_step (inputs: partial remainder, divisor, next dividend bit; outputs: new remainder, quotient bit).
REQ-032 SHALL contain no memories; all state in flops of div_sequencer.

Verification
REQ-033 SHALL cover: UDIV 57/8 -> done at start+67 cycles, quotient=7, remainder=1, stall high 66 cycles.
REQ-034 SHALL cover: SDIV -57/8 -> quotient=-7, remainder=-1; SDIV 57/-8 -> quotient=-7, remainder=1.
REQ-035 SHALL cover: UDIV 100/0 -> done 2 cycles after start, quotient=0, remainder=100, div_by_zero=1.
REQ-036 SHALL cover: SDIV 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0.
REQ-037 SHALL cover: start 57/8, second start (9/3) asserted during RUN -> ignored, single done with quotient=7.
REQ-038 SHALL cover: reset asserted at RUN cycle 20 -> next cycle IDLE, stall=0, outputs 0, no done; fresh 57/8 then completes correctly.
